// File: rtl/load_store_unit_if.sv
// Data-memory req/ack bus between the LSU (master) and memory (slave).
// Request fields are held stable while mem_req is high.
interface load_store_unit_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    mem_req;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH/8-1:0] mem_be;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   logic                    mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one req/ack access per instruction, stalls the
// core until the access completes, is rejected, or times out.
module load_store_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] ALU_Result,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  lsu_stall,
   output logic                  misaligned,
   output logic                  lsu_err,
   load_store_unit_if.master     mem
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam int CW =
      (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic                    timed_out;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [2:0]              f3_q;
   logic [1:0]              off_q;

   logic                    start;
   logic                    is_h;
   logic                    is_w;
   logic                    f3_ok;
   logic                    illegal;
   logic                    go;
   logic [1:0]              off;
   logic [3:0]              be_n;
   logic [DATA_WIDTH-1:0]   wdata_n;
   logic [7:0]              byte_v;
   logic [15:0]             half_v;

   assign start = MemRead ^ MemWrite;
   assign off   = ALU_Result[1:0];
   assign is_h  = (funct3[1:0] == 2'b01);
   assign is_w  = (funct3 == 3'b010);

   // Stores have no unsigned variants.
   assign f3_ok = MemWrite ? (funct3 inside {3'b000, 3'b001, 3'b010})
                           : (funct3 inside {3'b000, 3'b001, 3'b010,
                                             3'b100, 3'b101});

   assign illegal    = (MemRead & MemWrite) | (start & ~f3_ok);
   assign misaligned = start & ((is_h & off[0]) | (is_w & (|off)));
   assign go         = (state == IDLE) & start & f3_ok & ~misaligned;

   assign lsu_stall = go | (state == REQ);
   assign lsu_err   = ((state == IDLE) & illegal)
                    | ((state == DONE) & timed_out);

   always_comb begin
      be_n    = 4'b0001 << off;
      wdata_n = {4{store_data[7:0]}};
      unique case (1'b1)
         is_w: begin
            be_n    = 4'b1111;
            wdata_n = store_data;
         end
         is_h: begin
            be_n    = 4'b0011 << off;
            wdata_n = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      load_data = '0;
      byte_v    = rdata_q[{off_q, 3'b000} +: 8];
      half_v    = rdata_q[{off_q[1], 4'b0000} +: 16];
      if (state == DONE && !mem.mem_we && !timed_out) begin
         unique case (f3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            3'b001:  load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            3'b010:  load_data = rdata_q;
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
            default: load_data = '0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         timed_out     <= 1'b0;
         rdata_q       <= '0;
         f3_q          <= '0;
         off_q         <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_be    <= '0;
         mem.mem_wdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  state         <= REQ;
                  cnt           <= '0;
                  timed_out     <= 1'b0;
                  f3_q          <= funct3;
                  off_q         <= off;
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= MemWrite;
                  mem.mem_addr  <= {ALU_Result[ADDR_WIDTH-1:2], 2'b00};
                  mem.mem_be    <= be_n;
                  mem.mem_wdata <= wdata_n;
               end
            end
            REQ: begin
               // An ack on the expiry cycle still counts as success.
               if (mem.mem_ack) begin
                  rdata_q     <= mem.mem_rdata;
                  mem.mem_req <= 1'b0;
                  state       <= DONE;
               end else if (cnt == LAST) begin
                  timed_out   <= 1'b1;
                  mem.mem_req <= 1'b0;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a size/offset arithmetic
// model of RV32I load/store semantics and a behavioural memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] ALU_Result = '0;
   logic [31:0] store_data = '0;
   logic [31:0] load_data;
   logic        lsu_stall;
   logic        misaligned;
   logic        lsu_err;

   int n_checks = 0;
   int n_pass   = 0;

   load_store_unit_if mem ();

   load_store_unit dut (
      .CLK        (clk),
      .rst        (rst),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .funct3     (funct3),
      .ALU_Result (ALU_Result),
      .store_data (store_data),
      .load_data  (load_data),
      .lsu_stall  (lsu_stall),
      .misaligned (misaligned),
      .lsu_err    (lsu_err),
      .mem        (mem)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   function automatic int unsigned acc_size(input logic [2:0] f3);
      case (f3)
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 1;
      endcase
   endfunction

   function automatic bit f3_legal(input bit wr, input logic [2:0] f3);
      if (wr) return f3 <= 3'd2;
      return f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                            input int unsigned o,
                                            input logic [31:0] w);
      int unsigned b, h;
      b = (w >> (8 * o)) & 32'hFF;
      h = (w >> (16 * (o / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
         3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
         3'd2:    return w;
         3'd4:    return b;
         3'd5:    return h;
         default: return 0;
      endcase
   endfunction

   // delay < 0: memory never acks
   task automatic do_txn(input bit rd, input bit wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] rdat,
                         input int delay);
      bit          st, mis, err, go, tmo;
      int unsigned sz, o, n, exp_n;
      logic [31:0] exp_be, exp_wd, exp_ld;
      st    = rd ^ wr;
      sz    = acc_size(f3);
      o     = addr % 4;
      mis   = st && (addr % sz != 0) && sz > 1;
      err   = (rd && wr) || (st && !f3_legal(wr, f3));
      go    = st && !err && !mis;
      tmo   = !(delay >= 0 && delay < 16);
      exp_n = tmo ? 16 : delay + 1;
      exp_be = (sz == 4) ? 32'hF : (sz == 2 ? (32'h3 << o) : (32'h1 << o));
      exp_wd = (sz == 4) ? sd
             : (sz == 2 ? (sd & 32'hFFFF) * 32'h00010001
                        : (sd & 32'hFF) * 32'h01010101);
      exp_ld = (wr || tmo) ? 32'h0 : ref_load(f3, o, rdat);

      @(negedge clk);
      MemRead = rd; MemWrite = wr; funct3 = f3;
      ALU_Result = addr; store_data = sd;
      #1;
      check("misaligned", misaligned, mis);
      check("err_comb", lsu_err, err);
      check("stall_idle", lsu_stall, go);
      if (!go) begin
         @(negedge clk);
         check("no_req", mem.mem_req, 0);
         MemRead = 0; MemWrite = 0;
         return;
      end
      @(negedge clk);
      check("req", mem.mem_req, 1);
      check("we", mem.mem_we, wr);
      check("addr", mem.mem_addr, addr & 32'hFFFFFFFC);
      check("be", mem.mem_be, exp_be);
      if (wr) check("wdata", mem.mem_wdata, exp_wd);
      n = 0;
      while (mem.mem_req === 1'b1 && n < 40) begin
         if (lsu_stall !== 1'b1) check("stall_req", lsu_stall, 1);
         mem.mem_ack   = (delay >= 0 && n == delay);
         mem.mem_rdata = mem.mem_ack ? rdat : $urandom;
         @(negedge clk);
         mem.mem_ack = 0;
         n++;
      end
      check("req_cycles", n, exp_n);
      check("done_stall", lsu_stall, 0);
      check("done_err", lsu_err, tmo);
      check("load_data", load_data, exp_ld);
      MemRead = 0; MemWrite = 0;
      mem.mem_ack = 1; mem.mem_rdata = $urandom;
      @(negedge clk);
      check("idle_ld", load_data, 0);
      check("idle_req", mem.mem_req, 0);
      mem.mem_ack = 0;
   endtask

   initial begin
      mem.mem_ack   = 0;
      mem.mem_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_req", mem.mem_req, 0);
      check("rst_be", mem.mem_be, 0);
      check("rst_addr", mem.mem_addr, 0);
      check("rst_stall", lsu_stall, 0);
      check("rst_ld", load_data, 0);
      rst = 1;

      do_txn(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      do_txn(1, 0, 3'd0, 32'h103, 32'h0, 32'h80123456, 1);
      do_txn(1, 0, 3'd4, 32'h103, 32'h0, 32'h80123456, 2);
      do_txn(0, 1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0, 0);
      do_txn(1, 0, 3'd5, 32'h102, 32'h0, 32'hABCDABCD, 0);
      do_txn(1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
      do_txn(1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 0);
      do_txn(0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 0);
      do_txn(1, 0, 3'd2, 32'h200, 32'h0, 32'h12345678, -1);
      do_txn(1, 0, 3'd1, 32'h202, 32'h0, 32'h8001FFFF, 15);

      // reset while a request is outstanding
      @(negedge clk);
      MemRead = 1; funct3 = 3'd2; ALU_Result = 32'h300;
      @(negedge clk);
      check("mid_req", mem.mem_req, 1);
      rst = 0; MemRead = 0;
      @(negedge clk);
      check("abort_req", mem.mem_req, 0);
      check("abort_stall", lsu_stall, 0);
      rst = 1; mem.mem_ack = 1; mem.mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      check("abort_ld", load_data, 0);
      check("abort_err", lsu_err, 0);
      mem.mem_ack = 0;

      for (int i = 0; i < 200; i++) begin
         bit          rd, wr;
         logic [2:0]  f3;
         int          d;
         int unsigned k;
         k  = $urandom_range(0, 9);
         rd = (k < 5) || k == 9;
         wr = (k >= 5);
         f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom)
            : (wr ? 3'($urandom_range(0, 2))
                  : 3'(k % 3 == 0 ? $urandom_range(4, 5)
                                  : $urandom_range(0, 2)));
         k = $urandom_range(0, 19);
         d = (k == 0) ? -1 : (k == 1 ? 15 : int'($urandom_range(0, 4)));
         do_txn(rd, wr, f3, $urandom, $urandom, $urandom, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
